// File: rtl/ifu_fetch_if.sv
// Fetch-unit bus bundle: memory request/response channel plus the instruction
// channel towards execute. The fetch unit is the master on both.
interface ifu_fetch_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic        resp_err;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic [31:0] next_pc;
  logic        halt_req;

  modport master (
    output req_valid, req_addr,
    input  req_ready, resp_valid, resp_data, resp_err,
    output inst_valid, inst, inst_pc,
    input  inst_ready, next_pc, halt_req
  );

  modport slave (
    input  req_valid, req_addr,
    output req_ready, resp_valid, resp_data, resp_err,
    input  inst_valid, inst, inst_pc,
    output inst_ready, next_pc, halt_req
  );
endinterface

// File: rtl/ifu_fetch.sv
// Instruction fetch unit: owns the PC, issues one outstanding fetch at a time and
// hands {inst, inst_pc} to execute; sequencing comes solely from execute's next_pc.
module ifu_fetch #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter int unsigned CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  ifu_fetch_if.master      bus,
  output logic             halted,
  output logic             fault,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [2:0] {
    S_REQ,
    S_WAIT,
    S_HOLD,
    S_HALT,
    S_FAULT
  } state_t;

  state_t      state, state_nx;
  logic [31:0] pc;
  logic [31:0] inst_q;
  logic        fire;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_REQ;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx       = state;
    bus.req_valid  = 1'b0;
    bus.inst_valid = 1'b0;
    halted         = 1'b0;
    fault          = 1'b0;
    fire           = 1'b0;
    case (state)
      S_REQ: begin
        bus.req_valid = 1'b1;
        if (bus.req_ready) state_nx = S_WAIT;
      end
      S_WAIT: begin
        if (bus.resp_valid) state_nx = bus.resp_err ? S_FAULT : S_HOLD;
      end
      S_HOLD: begin
        bus.inst_valid = 1'b1;
        if (bus.inst_ready) begin
          fire = 1'b1;
          // ebreak wins over a misaligned target
          if (bus.halt_req)                 state_nx = S_HALT;
          else if (bus.next_pc[1:0] != 2'b00) state_nx = S_FAULT;
          else                              state_nx = S_REQ;
        end
      end
      S_HALT:  halted = 1'b1;
      S_FAULT: fault  = 1'b1;
      default: state_nx = S_FAULT;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc      <= RESET_PC;
      inst_q  <= '0;
      retired <= '0;
    end else begin
      if (state == S_WAIT && bus.resp_valid && !bus.resp_err)
        inst_q <= bus.resp_data;
      if (fire) begin
        retired <= retired + CNT_W'(1);
        pc      <= bus.next_pc;
      end
    end
  end

  // pc doubles as inst_pc, so a misaligned target stays visible in FAULT
  assign bus.req_addr = pc;
  assign bus.inst_pc  = pc;
  assign bus.inst     = inst_q;

endmodule
